// File: rtl/johnson_counter_pkg.sv
// Shared constants for the small sequence/phase generators.
// Other ring and Johnson style generators pick up their default width here.
package johnson_counter_pkg;

  localparam int JC_WIDTH = 4;

endpackage

// File: rtl/johnson_counter.sv
// Twisted-ring (Johnson) counter with a one-bit parallel fill-load.
// q walks the 2*WIDTH-state Johnson sequence and exposes the raw register state.
module johnson_counter
  import johnson_counter_pkg::*;
#(
  parameter int WIDTH = JC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             in,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= {WIDTH{in}};
    end else begin
      q <= {q[WIDTH-2:0], ~q[WIDTH-1]};
    end
  end

endmodule

// File: tb/tb_johnson_counter.sv
// Self-checking bench for johnson_counter.
// The reference model tracks the position in the Johnson sequence, not the bits.
module tb_johnson_counter;

  localparam int W = 4;
  localparam int PERIOD = 2 * W;

  logic         clk;
  logic         rst;
  logic         load;
  logic         in;
  logic [W-1:0] q;

  int vectors;
  int miscompares;
  int k;

  johnson_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .load(load),
    .in  (in),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Johnson state at sequence position idx: idx ones filling from the LSB,
  // then zeros filling from the LSB.
  function automatic logic [W-1:0] exp_q(input int idx);
    logic [W-1:0] ones;
    ones = '1;
    if (idx < W) return ones >> (W - idx);
    else         return ones << (idx - W);
  endfunction

  // Apply inputs during clock low, take one rising edge, update the model,
  // and return at the following falling edge.
  task automatic tick(input logic l, input logic i);
    load = l;
    in   = i;
    @(posedge clk);
    if (l) k = i ? W : 0;
    else   k = (k + 1) % PERIOD;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst  = 1'b0;
    load = 1'b0;
    in   = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    k   = 0;
    #1;
    vectors++;
    if (q !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async got=%b want=0000", q);
    end
    for (int n = 0; n < 2; n++) begin
      load = 1'b1;
      in   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if (q !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_hold[%0d] got=%b want=0000", n, q);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_free_count();
    logic [W-1:0] seq [8];
    seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    for (int n = 0; n < 8; n++) begin
      tick(1'b0, 1'b0);
      vectors++;
      if (q !== seq[n] || q !== exp_q(k)) begin
        miscompares++;
        $display("FAIL free_count[%0d] got=%b want=%b", n, q, seq[n]);
      end
    end
  endtask

  task automatic test_load_ones();
    logic [W-1:0] seq [3];
    seq = '{4'b1111, 4'b1110, 4'b1100};
    for (int n = 0; n < 7; n++) tick(1'b0, 1'b0);
    vectors++;
    if (q !== 4'b1000) begin
      miscompares++;
      $display("FAIL load_ones_pre got=%b want=1000", q);
    end
    for (int n = 0; n < 3; n++) begin
      tick(n == 0, 1'b1);
      vectors++;
      if (q !== seq[n]) begin
        miscompares++;
        $display("FAIL load_ones[%0d] got=%b want=%b", n, q, seq[n]);
      end
    end
  endtask

  task automatic test_load_zeros();
    // From 1100 (position 6) to 0111 (position 3) takes 5 count edges.
    for (int n = 0; n < 5; n++) tick(1'b0, 1'b0);
    vectors++;
    if (q !== 4'b0111) begin
      miscompares++;
      $display("FAIL load_zeros_pre got=%b want=0111", q);
    end
    tick(1'b1, 1'b0);
    vectors++;
    if (q !== 4'b0000) begin
      miscompares++;
      $display("FAIL load_zeros got=%b want=0000", q);
    end
    tick(1'b0, 1'b1);
    vectors++;
    if (q !== 4'b0001) begin
      miscompares++;
      $display("FAIL load_zeros_next got=%b want=0001", q);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b0);
    vectors++;
    if (q !== 4'b1110) begin
      miscompares++;
      $display("FAIL async_pre got=%b want=1110", q);
    end
    #1;
    rst = 1'b1;
    k   = 0;
    #1;
    vectors++;
    if (q !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_mid got=%b want=0000", q);
    end
    @(negedge clk);
    rst = 1'b0;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    vectors++;
    if (q !== 4'b0011) begin
      miscompares++;
      $display("FAIL async_resume got=%b want=0011", q);
    end
    rst  = 1'b1;
    load = 1'b1;
    in   = 1'b1;
    k    = 0;
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (q !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_over_load got=%b want=0000", q);
    end
    rst = 1'b0;
  endtask

  task automatic test_repeated_load();
    for (int n = 0; n < 3; n++) begin
      tick(1'b1, 1'b1);
      vectors++;
      if (q !== 4'b1111) begin
        miscompares++;
        $display("FAIL repeated_load[%0d] got=%b want=1111", n, q);
      end
    end
    tick(1'b0, 1'b0);
    vectors++;
    if (q !== 4'b1110) begin
      miscompares++;
      $display("FAIL repeated_release got=%b want=1110", q);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        #1;
        rst = 1'b1;
        k   = 0;
        #1;
        vectors++;
        if (q !== exp_q(k)) begin
          miscompares++;
          $display("FAIL random_reset[%0d] got=%b want=%b", n, q, exp_q(k));
        end
        @(negedge clk);
        rst = 1'b0;
      end else begin
        tick($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        vectors++;
        if (q !== exp_q(k)) begin
          miscompares++;
          $display("FAIL random[%0d] got=%b want=%b", n, q, exp_q(k));
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    k           = 0;
    test_reset();
    test_free_count();
    test_load_ones();
    test_load_zeros();
    test_async_reset();
    test_repeated_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
